// File: rtl/tx_rx_pkg.sv
// Shared types for the ROM-to-transmitter sequencer: FSM state encoding and
// the read latency of the registered-output ROM it drives.
package tx_rx_pkg;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        CAPTURE,
        SEND,
        FINISH
    } state_t;

    localparam int ROM_LATENCY = 1;

endpackage

// File: rtl/rom_tx_sequencer.sv
// Streams a block of ROM words (wrapping addresses) to the transmitter over a
// valid/ready handshake, one fetch per word with no prefetch.
module rom_tx_sequencer
    import tx_rx_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] start_addr,
    input  logic [ADDR_WIDTH:0]   len,
    input  logic                  abort,
    output logic [ADDR_WIDTH-1:0] rom_addr,
    output logic                  rom_read,
    input  logic [DATA_WIDTH-1:0] rom_q,
    output logic [DATA_WIDTH-1:0] tx_data,
    output logic                  tx_valid,
    input  logic                  tx_ready,
    output logic                  busy,
    output logic                  done
);

    state_t                state, state_next;
    logic [ADDR_WIDTH-1:0] addr, addr_next;
    logic [ADDR_WIDTH:0]   remaining, remaining_next;
    logic [DATA_WIDTH-1:0] data_reg, data_next;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            addr      <= '0;
            remaining <= '0;
            data_reg  <= '0;
        end else begin
            state     <= state_next;
            addr      <= addr_next;
            remaining <= remaining_next;
            data_reg  <= data_next;
        end
    end

    // Abort wins over a simultaneous tx_ready, so the offered word is not counted.
    always_comb begin
        state_next     = state;
        addr_next      = addr;
        remaining_next = remaining;
        data_next      = data_reg;
        case (state)
            IDLE: begin
                if (start) begin
                    if (len != '0) begin
                        addr_next      = start_addr;
                        remaining_next = len;
                        state_next     = FETCH;
                    end else begin
                        state_next = FINISH;
                    end
                end
            end
            FETCH: begin
                state_next = abort ? FINISH : CAPTURE;
            end
            CAPTURE: begin
                if (abort) begin
                    state_next = FINISH;
                end else begin
                    data_next  = rom_q;
                    state_next = SEND;
                end
            end
            SEND: begin
                if (abort) begin
                    state_next = FINISH;
                end else if (tx_ready) begin
                    remaining_next = remaining - (ADDR_WIDTH+1)'(1);
                    addr_next      = addr + ADDR_WIDTH'(1);
                    state_next     = (remaining == (ADDR_WIDTH+1)'(1)) ? FINISH : FETCH;
                end
            end
            FINISH: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Every output is a decode of registered state, so none depends on an input.
    assign rom_addr = addr;
    assign rom_read = (state == FETCH);
    assign tx_data  = data_reg;
    assign tx_valid = (state == SEND);
    assign busy     = (state != IDLE);
    assign done     = (state == FINISH);

endmodule
